// File: rtl/gamepad_pkg.sv
// Shared definitions for the serial gamepad poller: FSM states, button
// index constants and the default soft-reset button combination.
package gamepad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_UPDATE = 3'd4
  } poll_state_e;

  // NES button order as shifted out by the 4021 in the pad
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Extra SNES bits shifted after the NES-compatible eight
  localparam int BTN_SNES_A = 8;
  localparam int BTN_SNES_X = 9;
  localparam int BTN_SNES_L = 10;
  localparam int BTN_SNES_R = 11;

  // Select+Start on pad 0 requests a soft reset
  localparam logic [15:0] DEFAULT_RESET_MASK =
    (16'h0001 << BTN_SELECT) | (16'h0001 << BTN_START);

  // Larger of two integers, used to size the DAS counters
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/pad_autorepeat.sv
// One button's press-edge detector and delayed-autorepeat (DAS) counter.
// Everything advances only on the one-cycle update strobe; the outputs are
// registered single-cycle pulses.
module pad_autorepeat
  import gamepad_pkg::*;
#(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic update,
  input  logic held_new,
  output logic pressed,
  output logic repeat_pulse
);

  localparam int CW = $clog2(max_int(DAS_DELAY, DAS_RATE) + 1);

  logic          r_old;
  logic [CW-1:0] r_cnt;
  logic          r_pressed;
  logic          r_repeat;

  // Edge detect and DAS countdown, evaluated once per completed poll
  always_ff @(posedge clk) begin
    if (reset) begin
      r_old     <= 1'b0;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_repeat  <= 1'b0;
    end else if (update) begin
      r_old <= held_new;
      if (held_new && !r_old) begin
        r_pressed <= 1'b1;
        r_repeat  <= 1'b1;
        r_cnt     <= CW'(DAS_DELAY);
      end else if (held_new) begin
        r_pressed <= 1'b0;
        // a count of 1 reaches zero on this poll: fire and reload
        if (r_cnt <= CW'(1)) begin
          r_repeat <= 1'b1;
          r_cnt    <= CW'(DAS_RATE);
        end else begin
          r_repeat <= 1'b0;
          r_cnt    <= r_cnt - CW'(1);
        end
      end else begin
        r_pressed <= 1'b0;
        r_repeat  <= 1'b0;
        r_cnt     <= '0;
      end
    end else begin
      r_pressed <= 1'b0;
      r_repeat  <= 1'b0;
    end
  end

  assign pressed      = r_pressed;
  assign repeat_pulse = r_repeat;

endmodule

// File: rtl/gamepad_poller.sv
// Polls NUM_PADS serial NES/SNES pads on a shared latch/clock pair at a
// fixed rate and publishes held, press-edge and autorepeat strobes plus a
// held-combo soft-reset request. All outputs are registered and change
// only in the cycle after a poll's UPDATE state.
module gamepad_poller
  import gamepad_pkg::*;
#(
  parameter int                  NUM_PADS    = 2,
  parameter int                  NUM_BITS    = 8,
  parameter int                  HALF_PERIOD = 300,
  parameter int                  POLL_CYCLES = 833333,
  parameter int                  DAS_DELAY   = 16,
  parameter int                  DAS_RATE    = 6,
  parameter logic [NUM_BITS-1:0] RESET_MASK  = DEFAULT_RESET_MASK[NUM_BITS-1:0],
  parameter int                  RESET_POLLS = 60
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_held,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_repeat,
  output logic                         sample_valid,
  output logic                         nes_reset
);

  localparam int NB_TOT = NUM_PADS * NUM_BITS;
  localparam int PC_W   = $clog2(POLL_CYCLES);
  localparam int PH_W   = $clog2(2 * HALF_PERIOD);
  localparam int BIT_W  = $clog2(NUM_BITS);
  localparam int RC_W   = $clog2(RESET_POLLS + 1);

  localparam logic [PC_W-1:0]  POLL_LAST  = PC_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);

  poll_state_e                        r_state;
  poll_state_e                        w_next_state;
  logic [PC_W-1:0]                    r_poll_cnt;
  logic [PH_W-1:0]                    r_phase;
  logic [BIT_W-1:0]                   r_bit;
  // indexed [bit][pad] so one bit position of every pad loads at once
  logic [NUM_BITS-1:0][NUM_PADS-1:0]  r_shift;
  logic [NB_TOT-1:0]                  r_held;
  logic                               r_latch;
  logic                               r_pclk;
  logic                               r_valid;
  logic [RC_W-1:0]                    r_combo_cnt;
  logic                               r_nes_reset;
  logic                               w_update;
  logic [NB_TOT-1:0]                  w_held_new;
  logic [NB_TOT-1:0]                  w_pressed;
  logic [NB_TOT-1:0]                  w_repeat;

  assign w_update = (r_state == ST_UPDATE);

  // Free-running poll-rate counter; a wrap seen in IDLE starts a poll
  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt <= '0;
    end else if (r_poll_cnt == POLL_LAST) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + PC_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: latch pulse, then LOW/HIGH half periods per bit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_poll_cnt == POLL_LAST) w_next_state = ST_LATCH;
        else                         w_next_state = ST_IDLE;
      end
      ST_LATCH: begin
        if (r_phase == LATCH_LAST) w_next_state = ST_LOW;
        else                       w_next_state = ST_LATCH;
      end
      ST_LOW: begin
        if (r_phase == HALF_LAST) begin
          if (r_bit == BIT_LAST) w_next_state = ST_UPDATE;
          else                   w_next_state = ST_HIGH;
        end else begin
          w_next_state = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (r_phase == HALF_LAST) w_next_state = ST_LOW;
        else                      w_next_state = ST_HIGH;
      end
      ST_UPDATE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Cycle count within the current state, restarted on every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (r_state == ST_IDLE || w_next_state != r_state) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // Bit index: cleared during the latch, advanced at the end of each HIGH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit <= '0;
    end else if (r_state == ST_LATCH) begin
      r_bit <= '0;
    end else if (r_state == ST_HIGH && w_next_state == ST_LOW) begin
      r_bit <= r_bit + BIT_W'(1);
    end
  end

  // Sample every pad's data line on the last cycle of each LOW phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (r_state == ST_LOW && r_phase == HALF_LAST) begin
      r_shift[r_bit] <= pad_data;
    end
  end

  // Pad lines are active-low; flatten to pad*NUM_BITS + bit order
  for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
    for (genvar gb = 0; gb < NUM_BITS; gb++) begin : g_bit
      assign w_held_new[gp*NUM_BITS + gb] = ~r_shift[gb][gp];
    end
  end

  // Pad strobes follow the next state so they line up with the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch <= 1'b0;
      r_pclk  <= 1'b0;
      r_valid <= 1'b0;
      r_held  <= '0;
    end else begin
      r_latch <= (w_next_state == ST_LATCH);
      r_pclk  <= (w_next_state == ST_HIGH);
      r_valid <= w_update;
      if (w_update) begin
        r_held <= w_held_new;
      end
    end
  end

  // Combo counter: pulse once when pad 0 holds exactly RESET_MASK long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      r_combo_cnt <= '0;
      r_nes_reset <= 1'b0;
    end else if (w_update) begin
      if (w_held_new[NUM_BITS-1:0] == RESET_MASK) begin
        if (r_combo_cnt < RC_W'(RESET_POLLS)) begin
          r_combo_cnt <= r_combo_cnt + RC_W'(1);
          r_nes_reset <= (r_combo_cnt == RC_W'(RESET_POLLS - 1));
        end else begin
          r_nes_reset <= 1'b0;
        end
      end else begin
        r_combo_cnt <= '0;
        r_nes_reset <= 1'b0;
      end
    end else begin
      r_nes_reset <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NB_TOT; gi++) begin : g_btn
    pad_autorepeat #(
      .DAS_DELAY (DAS_DELAY),
      .DAS_RATE  (DAS_RATE)
    ) u_rep (
      .clk          (clk),
      .reset        (reset),
      .update       (w_update),
      .held_new     (w_held_new[gi]),
      .pressed      (w_pressed[gi]),
      .repeat_pulse (w_repeat[gi])
    );
  end

  assign pad_latch       = r_latch;
  assign pad_clk         = r_pclk;
  assign buttons_held    = r_held;
  assign buttons_pressed = w_pressed;
  assign buttons_repeat  = w_repeat;
  assign sample_valid    = r_valid;
  assign nes_reset       = r_nes_reset;

endmodule

// File: tb/tb_gamepad_poller.sv
// Bench for gamepad_poller: a two-pad NES instance exercised with directed
// per-poll vectors and a one-pad SNES instance with a fixed pattern. Each
// pad is a behavioural shift register driven by pad_latch/pad_clk.
module tb_gamepad_poller;

  typedef struct {
    logic [15:0] held;
    logic [15:0] pr;
    logic [15:0] rp;
    logic        nr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- NES instance: 2 pads x 8 bits ----------------
  logic [1:0]  pad_data_a;
  logic        latch_a, pclk_a, sv_a, nr_a;
  logic [15:0] held_a, pr_a, rp_a;
  logic [7:0]  btn0 = 8'h00;
  logic [7:0]  btn1 = 8'h00;
  int          idx_a = 0;
  logic        prev_a = 1'b0;

  gamepad_poller #(
    .NUM_PADS(2), .NUM_BITS(8), .HALF_PERIOD(2), .POLL_CYCLES(200),
    .DAS_DELAY(3), .DAS_RATE(2), .RESET_MASK(8'h0C), .RESET_POLLS(4)
  ) dut_a (
    .clk(clk), .reset(reset), .pad_data(pad_data_a),
    .pad_latch(latch_a), .pad_clk(pclk_a),
    .buttons_held(held_a), .buttons_pressed(pr_a), .buttons_repeat(rp_a),
    .sample_valid(sv_a), .nes_reset(nr_a)
  );

  always @(posedge clk) begin
    if (latch_a) idx_a <= 0;
    else if (pclk_a && !prev_a) idx_a <= idx_a + 1;
    prev_a <= pclk_a;
  end

  always_comb begin
    pad_data_a[0] = (idx_a < 8) ? ~btn0[idx_a[2:0]] : 1'b1;
    pad_data_a[1] = (idx_a < 8) ? ~btn1[idx_a[2:0]] : 1'b1;
  end

  // ---------------- SNES instance: 1 pad x 16 bits ----------------
  logic [0:0]  pad_data_b;
  logic        latch_b, pclk_b, sv_b, nr_b;
  logic [15:0] held_b, pr_b, rp_b;
  logic [15:0] btn_b = 16'h0A05;
  int          idx_b = 0;
  logic        prev_b = 1'b0;

  gamepad_poller #(
    .NUM_PADS(1), .NUM_BITS(16), .HALF_PERIOD(2), .POLL_CYCLES(200),
    .DAS_DELAY(3), .DAS_RATE(2), .RESET_MASK(16'h000C), .RESET_POLLS(4)
  ) dut_b (
    .clk(clk), .reset(reset), .pad_data(pad_data_b),
    .pad_latch(latch_b), .pad_clk(pclk_b),
    .buttons_held(held_b), .buttons_pressed(pr_b), .buttons_repeat(rp_b),
    .sample_valid(sv_b), .nes_reset(nr_b)
  );

  always @(posedge clk) begin
    if (latch_b) idx_b <= 0;
    else if (pclk_b && !prev_b) idx_b <= idx_b + 1;
    prev_b <= pclk_b;
  end

  always_comb begin
    pad_data_b[0] = (idx_b < 16) ? ~btn_b[idx_b[3:0]] : 1'b1;
  end

  // ---------------- scoreboards ----------------
  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] exp_held_cur = 16'h0000;

  // Monitor A: compare at each sample_valid, check quiet outputs otherwise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sv_a) begin
          if (q_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_a_unexpected: sample_valid with empty queue, held=%h", held_a);
          end else begin
            e = q_a.pop_front();
            chk("a_held", 32'(held_a), 32'(e.held));
            chk("a_pressed", 32'(pr_a), 32'(e.pr));
            chk("a_repeat", 32'(rp_a), 32'(e.rp));
            chk("a_nes_reset", 32'(nr_a), 32'(e.nr));
            exp_held_cur = e.held;
          end
        end else begin
          chk("a_held_stable", 32'(held_a), 32'(exp_held_cur));
          chk("a_quiet", {15'd0, nr_a, pr_a}, 32'd0);
          chk("a_quiet_rep", 32'(rp_a), 32'd0);
        end
      end
    end
  end

  // Timing monitor for instance A: latch width, clock pulses, poll period
  initial begin
    int   t_latch, t_rise, t_hi, t_since;
    bit   t_have;
    logic t_prev;
    t_latch = 0; t_rise = 0; t_hi = 0; t_since = 0; t_have = 0; t_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        t_latch = 0; t_rise = 0; t_hi = 0; t_since = 0; t_have = 0; t_prev = 1'b0;
      end else begin
        t_since++;
        if (latch_a) t_latch++;
        if (pclk_a) t_hi++;
        if (pclk_a && !t_prev) t_rise++;
        t_prev = pclk_a;
        if (sv_a) begin
          chk("latch_width", 32'(t_latch), 32'd4);
          chk("clk_rises", 32'(t_rise), 32'd7);
          chk("clk_high_cycles", 32'(t_hi), 32'd14);
          if (t_have) chk("poll_period", 32'(t_since), 32'd200);
          t_have = 1;
          t_latch = 0; t_rise = 0; t_hi = 0; t_since = 0;
        end
      end
    end
  end

  // Monitor B: SNES pattern decode and clock pulse count
  initial begin
    exp_t e;
    int   rises;
    logic pv;
    rises = 0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rises = 0; pv = 1'b0;
      end else begin
        if (pclk_b && !pv) rises++;
        pv = pclk_b;
        if (sv_b && q_b.size() > 0) begin
          e = q_b.pop_front();
          chk("b_clk_rises", 32'(rises), 32'd15);
          chk("b_held", 32'(held_b), 32'(e.held));
          chk("b_pressed", 32'(pr_b), 32'(e.pr));
          chk("b_repeat", 32'(rp_b), 32'(e.rp));
          chk("b_nes_reset", 32'(nr_b), 32'(e.nr));
          rises = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_sv_a(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sv_a && n < 400);
    if (!sv_a) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no sample_valid after %0d cycles, expected within 400", nm, n);
    end
  endtask

  // Apply one pad pattern for one poll and queue its expected response
  task automatic poll(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [15:0] pr, input logic [15:0] rp, input logic nr);
    exp_t e;
    btn0 = b0;
    btn1 = b1;
    e.held = {b1, b0};
    e.pr = pr;
    e.rp = rp;
    e.nr = nr;
    q_a.push_back(e);
    wait_sv_a("poll");
  endtask

  initial begin
    exp_t eb;
    int   n, rises;
    logic pv;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pad_latch", 32'(latch_a), 32'd0);
    chk("rst_pad_clk", 32'(pclk_a), 32'd0);
    chk("rst_held", 32'(held_a), 32'd0);
    chk("rst_pulses", {15'd0, nr_a, pr_a}, 32'd0);
    chk("rst_valid_rep", {15'd0, sv_a, rp_a}, 32'd0);

    eb.held = 16'h0A05; eb.pr = 16'h0A05; eb.rp = 16'h0A05; eb.nr = 1'b0;
    q_b.push_back(eb);
    eb.pr = 16'h0000; eb.rp = 16'h0000;
    q_b.push_back(eb);

    reset = 1'b0;

    // idle timing and decode
    poll(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
    poll(8'h41, 8'h08, 16'h0841, 16'h0841, 1'b0);
    poll(8'h41, 8'h08, 16'h0000, 16'h0000, 1'b0);
    poll(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);

    // DOWN held 10 polls: repeats at 1,4,6,8,10, then release
    for (int i = 1; i <= 10; i++) begin
      poll(8'h20, 8'h00, (i == 1) ? 16'h0020 : 16'h0000,
           (i == 1 || i == 4 || i == 6 || i == 8 || i == 10) ? 16'h0020 : 16'h0000, 1'b0);
    end
    poll(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);

    // Select+Start 6 polls: one nes_reset after the 4th
    for (int i = 1; i <= 6; i++) begin
      poll(8'h0C, 8'h00, (i == 1) ? 16'h000C : 16'h0000,
           (i == 1 || i == 4 || i == 6) ? 16'h000C : 16'h0000, (i == 4));
    end

    // Select+Start+A 6 polls: not an exact match, never resets
    poll(8'h0D, 8'h00, 16'h0001, 16'h0001, 1'b0);
    poll(8'h0D, 8'h00, 16'h0000, 16'h000C, 1'b0);
    poll(8'h0D, 8'h00, 16'h0000, 16'h0000, 1'b0);
    poll(8'h0D, 8'h00, 16'h0000, 16'h000D, 1'b0);
    poll(8'h0D, 8'h00, 16'h0000, 16'h0000, 1'b0);
    poll(8'h0D, 8'h00, 16'h0000, 16'h000D, 1'b0);
    poll(8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
    poll(8'h20, 8'h00, 16'h0020, 16'h0020, 1'b0);

    // Reset during the HIGH phase with bit index 3 (fourth pad_clk rise)
    btn0 = 8'h20;
    btn1 = 8'h08;
    n = 0; rises = 0; pv = pclk_a;
    while (rises < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (pclk_a && !pv) rises++;
      pv = pclk_a;
    end
    chk("midshift_rises_seen", 32'(rises), 32'd4);
    reset = 1'b1;
    exp_held_cur = 16'h0000;
    q_a.delete();
    @(negedge clk);
    chk("midrst_pad_clk", 32'(pclk_a), 32'd0);
    chk("midrst_pad_latch", 32'(latch_a), 32'd0);
    chk("midrst_held", 32'(held_a), 32'd0);
    chk("midrst_pulses", {15'd0, nr_a, pr_a}, 32'd0);
    chk("midrst_valid_rep", {15'd0, sv_a, rp_a}, 32'd0);
    reset = 1'b0;
    begin
      exp_t e;
      e.held = 16'h0820; e.pr = 16'h0820; e.rp = 16'h0820; e.nr = 1'b0;
      q_a.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!latch_a && n < 400);
    chk("latch_after_reset", 32'(n), 32'd200);
    wait_sv_a("post_reset");
    poll(8'h20, 8'h08, 16'h0000, 16'h0000, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_a_drain", 32'(q_a.size()), 32'd0);
    chk("sb_b_drain", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
